// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a dual-port VRAM between video fetch and the CPU.
// Port 1 carries arbitrated reads through a three-stage pipeline
// (issue, RAM, return). Port 2 carries CPU writes through a registered
// write stage. A write accepted at the same edge as a read to the same
// address is forwarded into that read's return data. Video has read
// priority; a starvation counter forces a pending CPU read through
// after MAXWAIT refused edges.
module vram_arbiter #(
    parameter int unsigned AW      = 14,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic          clock,
    input  logic          reset,

    // Request/grant handshake: a requester holds req (and its address)
    // high; the read is accepted on the rising edge where req && gnt are
    // both high. gnt is combinational from the requests and the starvation
    // counter. Each accepted read produces exactly one one-cycle valid
    // pulse with its data three edges later, in accept order.
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic          vid_gnt,
    output logic          vid_valid,
    output logic [DW-1:0] vid_q,

    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic          cpu_gnt,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_q,

    output logic          ram_ce1,
    output logic [AW-1:0] ram_a1,
    input  logic [DW-1:0] ram_q1,

    output logic          ram_ce2,
    output logic          ram_we2,
    output logic [AW-1:0] ram_a2,
    output logic [DW-1:0] ram_d2
);

    localparam logic [3:0] MAXW = 4'(MAXWAIT);

    logic [3:0]    wait_cnt;
    logic          force_cpu;
    logic          rd_acc;
    logic [AW-1:0] rd_addr;
    logic          rd_fwd;

    // Issue-stage side information travelling alongside ram_ce1/ram_a1
    logic          iss_cpu;
    logic          iss_fwd;
    logic [DW-1:0] iss_fd;

    // RAM-stage side information, aligned with ram_q1
    logic          mem_v;
    logic          mem_cpu;
    logic          mem_fwd;
    logic [DW-1:0] mem_fd;
    logic [DW-1:0] ret_d;

    // Arbitration: video wins unless the CPU has been refused MAXWAIT times
    always_comb begin
        force_cpu = (wait_cnt == MAXW);
        vid_gnt   = vid_req && !force_cpu;
        cpu_gnt   = cpu_rd && !vid_gnt;
        rd_acc    = vid_gnt || cpu_gnt;
        rd_addr   = cpu_gnt ? cpu_a : vid_a;
        // A same-edge write reaches the RAM together with the read, which
        // then sees the old contents; remember to substitute the write data.
        rd_fwd    = cpu_wr && (cpu_a == rd_addr);
        ret_d     = mem_fwd ? mem_fd : ram_q1;
    end

    // Starvation counter: counts consecutive refused CPU read edges
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (cpu_gnt || !cpu_rd) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAXW) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Issue stage: present the accepted read to RAM port 1
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_ce1 <= 1'b0;
            ram_a1  <= '0;
            iss_cpu <= 1'b0;
            iss_fwd <= 1'b0;
            iss_fd  <= '0;
        end else begin
            ram_ce1 <= rd_acc;
            iss_cpu <= cpu_gnt;
            iss_fwd <= rd_acc && rd_fwd;
            if (rd_acc) begin
                ram_a1 <= rd_addr;
                iss_fd <= cpu_d;
            end
        end
    end

    // RAM stage: track the read while the RAM produces ram_q1
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_v   <= 1'b0;
            mem_cpu <= 1'b0;
            mem_fwd <= 1'b0;
            mem_fd  <= '0;
        end else begin
            mem_v   <= ram_ce1;
            mem_cpu <= iss_cpu;
            mem_fwd <= iss_fwd;
            mem_fd  <= iss_fd;
        end
    end

    // Return stage: steer data to its owner and pulse the matching valid
    always_ff @(posedge clock) begin
        if (reset) begin
            vid_valid <= 1'b0;
            cpu_valid <= 1'b0;
            vid_q     <= '0;
            cpu_q     <= '0;
        end else begin
            vid_valid <= mem_v && !mem_cpu;
            cpu_valid <= mem_v && mem_cpu;
            if (mem_v && !mem_cpu) begin
                vid_q <= ret_d;
            end
            if (mem_v && mem_cpu) begin
                cpu_q <= ret_d;
            end
        end
    end

    // Write stage: every CPU write is staged onto port 2 for one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_ce2 <= 1'b0;
            ram_we2 <= 1'b1;
            ram_a2  <= '0;
            ram_d2  <= '0;
        end else begin
            ram_ce2 <= cpu_wr;
            ram_we2 <= !cpu_wr;
            if (cpu_wr) begin
                ram_a2 <= cpu_a;
                ram_d2 <= cpu_d;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed vectors, a VRAM model, and a
// scoreboard that pairs every valid pulse with an expected value and cycle.
module tb_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_a = '0;
    logic          vid_gnt, vid_valid;
    logic [DW-1:0] vid_q;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_a = '0;
    logic [DW-1:0] cpu_d = '0;
    logic          cpu_gnt, cpu_valid;
    logic [DW-1:0] cpu_q;
    logic          ram_ce1, ram_ce2, ram_we2;
    logic [AW-1:0] ram_a1, ram_a2;
    logic [DW-1:0] ram_q1, ram_d2;

    vram_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(4)) dut (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_a(vid_a), .vid_gnt(vid_gnt),
        .vid_valid(vid_valid), .vid_q(vid_q),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_q(cpu_q),
        .ram_ce1(ram_ce1), .ram_a1(ram_a1), .ram_q1(ram_q1),
        .ram_ce2(ram_ce2), .ram_we2(ram_we2), .ram_a2(ram_a2), .ram_d2(ram_d2)
    );

    // ---------------- VRAM model (registered read, read-first) ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic preload = 1'b0;
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i);
            mem[14'h0040] <= 8'h11;
        end else begin
            if (ram_ce1) ram_q1 <= mem[ram_a1];
            if (ram_ce2 && !ram_we2) mem[ram_a2] <= ram_d2;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] vid_exp_q[$];
    logic [DW-1:0] cpu_exp_q[$];
    int vid_cyc_q[$];
    int cpu_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation
    logic [DW-1:0] v_e, c_e;
    int v_c, c_c;
    always @(negedge clock) begin
        if (vid_valid === 1'b1) begin
            if (vid_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vid_unexpected actual=%0h expected=no_pulse (cycle %0d)", vid_q, cyc);
            end else begin
                v_e = vid_exp_q.pop_front();
                v_c = vid_cyc_q.pop_front();
                check("vid_q", 64'(vid_q), 64'(v_e));
                check("vid_latency", 64'(cyc), 64'(v_c));
            end
        end
        if (cpu_valid === 1'b1) begin
            if (cpu_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_unexpected actual=%0h expected=no_pulse (cycle %0d)", cpu_q, cyc);
            end else begin
                c_e = cpu_exp_q.pop_front();
                c_c = cpu_cyc_q.pop_front();
                check("cpu_q", 64'(cpu_q), 64'(c_e));
                check("cpu_latency", 64'(cyc), 64'(c_c));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic vreq, input logic [AW-1:0] va, input logic crd,
                         input logic cwr, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        @(negedge clock);
        vid_req = vreq; vid_a = va;
        cpu_rd = crd; cpu_wr = cwr; cpu_a = ca; cpu_d = cd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Drive one cycle, check grants, and queue the expected read data
    task automatic step(input string name, input logic vreq, input logic [AW-1:0] va,
                        input logic crd, input logic cwr, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic exp_vg, input logic exp_cg,
                        input logic [DW-1:0] vexp, input logic [DW-1:0] cexp, input bit push);
        drive(vreq, va, crd, cwr, ca, cd);
        check({name, "_vid_gnt"}, 64'(vid_gnt), 64'(exp_vg));
        check({name, "_cpu_gnt"}, 64'(cpu_gnt), 64'(exp_cg));
        if (push && exp_vg) begin
            vid_exp_q.push_back(vexp);
            vid_cyc_q.push_back(cyc + 3);
        end
        if (push && exp_cg) begin
            cpu_exp_q.push_back(cexp);
            cpu_cyc_q.push_back(cyc + 3);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({vid_gnt, cpu_gnt, ram_ce1, ram_a1, ram_ce2, ram_we2, ram_a2, ram_d2,
                    vid_valid, cpu_valid, vid_q, cpu_q});
    endfunction

    localparam logic [63:0] RESET_VEC = 64'({1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1, 14'h0,
                                             8'h0, 1'b0, 1'b0, 8'h0, 8'h0});

    // ---------------- stimulus ----------------
    initial begin
        int k;
        // Reset and preload RAM
        preload = 1'b1;
        @(negedge clock);
        preload = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset, then idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            idle();
            check("idle_outputs", out_vec(), RESET_VEC);
        end

        // Video-only burst 0x100..0x107, data = low address byte
        for (int i = 0; i < 8; i++)
            step("vburst", 1'b1, 14'(14'h100 + i), 1'b0, 1'b0, '0, '0,
                 1'b1, 1'b0, 8'(i), 8'h0, 1'b1);
        repeat (5) idle();
        check("vburst_drained", 64'(vid_exp_q.size()), 64'd0);

        // Starvation: two rounds of 4 refusals then a forced CPU grant
        k = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                step("starve_refuse", 1'b1, 14'(14'h200 + k), 1'b1, 1'b0, 14'h305, '0,
                     1'b1, 1'b0, 8'(k), 8'h0, 1'b1);
                k++;
            end
            step("starve_force", 1'b1, 14'h2FF, 1'b1, 1'b0, 14'h305, '0,
                 1'b0, 1'b1, 8'h0, 8'h05, 1'b1);
        end
        repeat (5) idle();

        // Collision forwarding at 0x0040, then re-read and neighbour
        step("coll_same_edge", 1'b1, 14'h0040, 1'b0, 1'b1, 14'h0040, 8'hA5,
             1'b1, 1'b0, 8'hA5, 8'h0, 1'b1);
        step("coll_next_edge", 1'b1, 14'h0040, 1'b0, 1'b0, '0, '0,
             1'b1, 1'b0, 8'hA5, 8'h0, 1'b1);
        step("coll_neighbour", 1'b1, 14'h0041, 1'b0, 1'b0, '0, '0,
             1'b1, 1'b0, 8'h41, 8'h0, 1'b1);
        repeat (5) idle();

        // Simultaneous CPU read+write, no video
        step("simul", 1'b0, '0, 1'b1, 1'b1, 14'h2000, 8'h3C,
             1'b0, 1'b1, 8'h0, 8'h3C, 1'b1);
        idle();
        check("simul_wr_stage", 64'({ram_ce2, ram_we2, ram_a2, ram_d2}),
              64'({1'b1, 1'b0, 14'h2000, 8'h3C}));
        idle();
        check("simul_wr_one_cycle", 64'({ram_ce2, ram_we2}), 64'({1'b0, 1'b1}));
        repeat (4) idle();

        // Back-to-back writes, then read both back
        step("b2b_wr0", 1'b0, '0, 1'b0, 1'b1, 14'h0050, 8'h77, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        step("b2b_wr1", 1'b0, '0, 1'b0, 1'b1, 14'h0051, 8'h88, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        check("b2b_stage0", 64'({ram_we2, ram_a2, ram_d2}), 64'({1'b0, 14'h0050, 8'h77}));
        step("b2b_rd0", 1'b0, '0, 1'b1, 1'b0, 14'h0050, '0, 1'b0, 1'b1, 8'h0, 8'h77, 1'b1);
        check("b2b_stage1", 64'({ram_we2, ram_a2, ram_d2}), 64'({1'b0, 14'h0051, 8'h88}));
        step("b2b_rd1", 1'b0, '0, 1'b1, 1'b0, 14'h0051, '0, 1'b0, 1'b1, 8'h0, 8'h88, 1'b1);
        check("b2b_done", 64'(ram_we2), 64'd1);
        repeat (5) idle();
        check("queues_drained", 64'(vid_exp_q.size() + cpu_exp_q.size()), 64'd0);

        // Reset one edge after two accepted reads: nothing may return
        step("rst_rd_vid", 1'b1, 14'h0010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        step("rst_rd_cpu", 1'b0, '0, 1'b1, 1'b1, 14'h0011, 8'h5A, 1'b0, 1'b1, 8'h0, 8'h0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        vid_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge clock);
        #1;
        check("rst_ports", 64'({ram_ce1, ram_we2, ram_ce2}), 64'({1'b0, 1'b1, 1'b0}));
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            check("rst_no_valid", 64'({vid_valid, cpu_valid}), 64'd0);
        end
        check("rst_outputs", out_vec(), RESET_VEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one dual-port video RAM (port 1 registered read, port 2 write with active-low write enable) between the video fetch engine and the CPU. Video fetch has priority on the read port, and a starvation counter guarantees CPU reads a bounded wait. CPU writes go through a registered write stage on port 2. Same-address read/write collisions are forwarded so every read returns coherent data. The block sits between the Z80 bus interface, the video timing generator and the VRAM instance.

## Interface
- AW, 14: RAM address width (16 KB).
- DW, 8: data width.
- MAXWAIT, 4: cycles a pending CPU read may be refused before it is forced through (1..15).

- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video read request, address valid.
- vid_a  in  AW  video read address.
- vid_gnt  out  1  combinational; read accepted at this edge when vid_req && vid_gnt.
- vid_valid  out  1  one-cycle pulse, vid_q valid.
- vid_q  out  DW  video read data.
- cpu_rd  in  1  CPU read request.
- cpu_wr  in  1  CPU write request (always accepted).
- cpu_a  in  AW  CPU address.
- cpu_d  in  DW  CPU write data.
- cpu_gnt  out  1  combinational; read accepted when cpu_rd && cpu_gnt.
- cpu_valid  out  1  one-cycle pulse, cpu_q valid.
- cpu_q  out  DW  CPU read data.
- ram_ce1  out  1  port-1 read enable.
- ram_a1  out  AW  port-1 address.
- ram_q1  in  DW  port-1 data, registered in RAM, valid one edge after ram_ce1/ram_a1 are sampled.
- ram_ce2  out  1  port-2 enable.
- ram_we2  out  1  port-2 write strobe, active low.
- ram_a2  out  AW  port-2 address.
- ram_d2  out  DW  port-2 write data.

## Operation
- force_cpu = (wait_cnt == MAXWAIT).
- vid_gnt = vid_req && !force_cpu.
- cpu_gnt = cpu_rd && !(vid_req && !force_cpu). At most one read is accepted per edge.
- The same cpu_a is used for cpu_rd and cpu_wr. When both are asserted, both are handled. The read is subject to arbitration; the write is always accepted.
- wait_cnt (4 bits):
  - Clears on any edge with cpu_gnt, or with !cpu_rd.
  - Otherwise increments, saturating at MAXWAIT.
- Read pipeline, three stages:
  - ISSUE: ram_ce1, ram_a1, owner bit and address are registered at the accept edge.
  - RAM: ram_q1 is produced at the next edge.
  - RETURN: at the following edge, data is registered into vid_q or cpu_q by owner, and the matching valid pulses for one cycle.
  - With ram_ce1 low, nothing propagates and no valid is generated.
- Write stage:
  - At an edge with cpu_wr, register ram_ce2=1, ram_we2=0, ram_a2=cpu_a, ram_d2=cpu_d for exactly one cycle.
  - Otherwise ram_ce2=0 and ram_we2=1.
  - Back-to-back writes issue every cycle.
- Forwarding:
  - A read and a write accepted at the same edge reach the RAM at the same edge, so the RAM returns old data.
  - If the addresses match, the RETURN stage substitutes the write data.
  - A write accepted one or more edges before a read needs no forwarding.
  - Requirement: a read returns the value of the latest write accepted at or before the read's accept edge.
- Reset:
  - Outputs: ram_ce1=0, ram_a1=0, ram_ce2=0, ram_we2=1, ram_a2=0, ram_d2=0, vid_valid=0, cpu_valid=0, vid_q=0, cpu_q=0.
  - Internal: wait_cnt=0, pipeline owner/valid bits cleared.
  - Reset mid-operation discards all in-flight reads (no valid pulse afterwards) and the pending write stage (ram_we2 returns high at the reset edge).

## Timing
- A read accepted at edge E drives ram_ce1/ram_a1 after E. RAM data appears after E+1. *_valid/*_q are high in the cycle after E+2 (latency 3 edges).
- Fully pipelined: one read per cycle sustained, in accept order.
- Write accepted at edge E is presented to the RAM after E and committed at E+1.
- vid_gnt/cpu_gnt are combinational from requests and wait_cnt. There is no combinational path from ram_q1 to any output.
- Worst-case CPU read wait is MAXWAIT refused edges. It is granted at the next edge even with vid_req high, and vid_gnt is low that cycle.

## Test plan
- Reset, then idle:
  - All outputs hold their reset values.
  - ram_we2=1.
  - No valid pulses for 20 cycles.
- Video-only burst, vid_a=0x100..0x107 on consecutive edges, RAM preloaded with data = address low byte:
  - vid_valid high 8 consecutive cycles starting 3 edges after the first accept.
  - vid_q = 0x00..0x07.
- Starvation, MAXWAIT=4, vid_req held high, cpu_rd held:
  - cpu_gnt low for 4 edges and high at the 5th, with vid_gnt low that cycle.
  - cpu_valid follows 3 edges later.
  - wait_cnt returns to 0.
- Collision: cpu_wr to 0x0040 with d=0xA5 at the same edge a video read of 0x0040 is accepted (old RAM value 0x11):
  - vid_q = 0xA5.
  - A read of 0x0040 one edge later also returns 0xA5.
  - A read of 0x0041 returns its unchanged value.
- Simultaneous cpu_rd+cpu_wr, no video, cpu_a=0x2000, d=0x3C:
  - ram_we2 low for one cycle.
  - cpu_q=0x3C after 3 edges.
- Reset asserted one edge after two reads are accepted:
  - No vid_valid or cpu_valid pulse appears.
  - ram_ce1=0 and ram_we2=1 after the reset edge.
